dl_frame_builder: RTL and testbench



---
 rtl/fec_pkg.sv | 19 +
 rtl/dl_frame_builder.sv | 158 +++++++++++++++
 tb/tb_dl_frame_builder.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fec_pkg.sv
// Shared FEC field widths plus the downlink frame builder's frame geometry and FSM states.
package fec_pkg;

    localparam int CRC0_WIDTH      = 8;
    localparam int CRC1_WIDTH      = 4;
    localparam int ENC0_DATA_DEPTH = 8;
    localparam int ENC1_DATA_DEPTH = 4;

    localparam int DLF_FRM_BYTES     = 14;
    localparam int DLF_PAYLOAD_BYTES = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        SEND
    } dlf_state_t;

endpackage

// File: rtl/dl_frame_builder.sv
// Sequences the FEC engine for one downlink frame, then streams 14 bytes out (first byte one cycle after the later done).
// Byte index advances only on tx_valid && tx_ready; new frames are accepted only in IDLE, never queued.
module dl_frame_builder
    import fec_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  frm_valid,
    output logic                                  frm_ready,
    input  logic [DLF_PAYLOAD_BYTES-1:0][7:0]     data_in,
    input  logic [7:0]                            msg_len,
    input  logic [3:0]                            msg_tag,
    output logic [DLF_PAYLOAD_BYTES-1:0][7:0]     eng_data,
    output logic [7:0]                            eng_msg_len,
    output logic [3:0]                            eng_msg_tag,
    output logic                                  crc0_start,
    output logic                                  crc1_start,
    input  logic                                  enc0_done,
    input  logic                                  enc1_done,
    input  logic [CRC0_WIDTH-1:0]                 crc0_data,
    input  logic [ENC0_DATA_DEPTH-1:0]            enc0_row_p,
    input  logic [ENC0_DATA_DEPTH-1:0]            enc0_col_p,
    input  logic [CRC1_WIDTH-1:0]                 crc1_data,
    input  logic [ENC1_DATA_DEPTH-1:0]            enc1_row_p,
    input  logic [ENC1_DATA_DEPTH-1:0]            enc1_col_p,
    output logic [7:0]                            tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy,
    output logic                                  timeout_err
);

    dlf_state_t                 state_q, state_d;
    logic                       alive_q;
    logic [3:0]                 idx_q;
    logic [15:0]                cnt_q;
    logic                       flag0_q, flag1_q;
    logic [CRC0_WIDTH-1:0]      crc0_q;
    logic [ENC0_DATA_DEPTH-1:0] row0_q, col0_q;
    logic [CRC1_WIDTH-1:0]      crc1_q;
    logic [ENC1_DATA_DEPTH-1:0] row1_q, col1_q;
    logic [7:0]                 frame_byte;

    logic accept, tx_fire, both_done, expire, last_byte;

    // alive_q keeps frm_ready low while reset is held and until the first edge after release.
    assign frm_ready  = alive_q && (state_q == IDLE);
    assign accept     = frm_valid && frm_ready;
    assign crc0_start = (state_q == START);
    assign crc1_start = (state_q == START);
    assign tx_valid   = (state_q == SEND);
    assign busy       = (state_q != IDLE);
    assign tx_fire    = tx_valid && tx_ready;
    assign both_done  = (flag0_q || enc0_done) && (flag1_q || enc1_done);
    assign expire     = (cnt_q == 16'(TIMEOUT_CYC - 1));
    assign last_byte  = (idx_q == 4'(DLF_FRM_BYTES - 1));
    assign tx_data    = tx_valid ? frame_byte : 8'h00;

    always_comb begin
        state_d     = state_q;
        timeout_err = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                // Completion wins over a timeout expiring in the same cycle.
                if (both_done) begin
                    state_d = SEND;
                end else if (expire) begin
                    state_d     = IDLE;
                    timeout_err = 1'b1;
                end
            end
            SEND:    if (tx_fire && last_byte) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            4'd0:    frame_byte = SYNC_BYTE;
            4'd1:    frame_byte = eng_msg_len;
            4'd2:    frame_byte = {eng_msg_tag, crc1_q};
            4'd3:    frame_byte = {row1_q, col1_q};
            4'd4:    frame_byte = eng_data[0];
            4'd5:    frame_byte = eng_data[1];
            4'd6:    frame_byte = eng_data[2];
            4'd7:    frame_byte = eng_data[3];
            4'd8:    frame_byte = eng_data[4];
            4'd9:    frame_byte = eng_data[5];
            4'd10:   frame_byte = eng_data[6];
            4'd11:   frame_byte = crc0_q;
            4'd12:   frame_byte = row0_q;
            4'd13:   frame_byte = col0_q;
            default: frame_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alive_q     <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            flag0_q     <= 1'b0;
            flag1_q     <= 1'b0;
            crc0_q      <= '0;
            row0_q      <= '0;
            col0_q      <= '0;
            crc1_q      <= '0;
            row1_q      <= '0;
            col1_q      <= '0;
            eng_data    <= '0;
            eng_msg_len <= '0;
            eng_msg_tag <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            if (accept) begin
                eng_data    <= data_in;
                eng_msg_len <= msg_len;
                eng_msg_tag <= msg_tag;
            end
            case (state_q)
                START: begin
                    flag0_q <= 1'b0;
                    flag1_q <= 1'b0;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (enc0_done) begin
                        flag0_q <= 1'b1;
                        crc0_q  <= crc0_data;
                        row0_q  <= enc0_row_p;
                        col0_q  <= enc0_col_p;
                    end
                    if (enc1_done) begin
                        flag1_q <= 1'b1;
                        crc1_q  <= crc1_data;
                        row1_q  <= enc1_row_p;
                        col1_q  <= enc1_col_p;
                    end
                end
                SEND: begin
                    if (tx_fire) idx_q <= last_byte ? 4'd0 : idx_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dl_frame_builder.sv
// Randomized bench for dl_frame_builder: stub FEC engine, expected-frame queue and one per-cycle compare process.
module tb_dl_frame_builder;

    localparam int         TO   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frm_valid, frm_ready;
    logic [6:0][7:0] data_in, eng_data;
    logic [7:0]      msg_len, eng_msg_len;
    logic [3:0]      msg_tag, eng_msg_tag;
    logic            crc0_start, crc1_start, enc0_done, enc1_done;
    logic [7:0]      crc0_data, enc0_row_p, enc0_col_p;
    logic [3:0]      crc1_data, enc1_row_p, enc1_col_p;
    logic [7:0]      tx_data;
    logic            tx_valid, tx_ready, busy, timeout_err;

    always #5 clk = ~clk;

    dl_frame_builder #(.SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .frm_valid(frm_valid), .frm_ready(frm_ready),
        .data_in(data_in), .msg_len(msg_len), .msg_tag(msg_tag),
        .eng_data(eng_data), .eng_msg_len(eng_msg_len), .eng_msg_tag(eng_msg_tag),
        .crc0_start(crc0_start), .crc1_start(crc1_start),
        .enc0_done(enc0_done), .enc1_done(enc1_done),
        .crc0_data(crc0_data), .enc0_row_p(enc0_row_p), .enc0_col_p(enc0_col_p),
        .crc1_data(crc1_data), .enc1_row_p(enc1_row_p), .enc1_col_p(enc1_col_p),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    int n_tests = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    int byte_cnt = 0, frames_done = 0, n_acc = 0, n_st0 = 0, n_st1 = 0, n_to = 0;
    int exp_to = 0, exp_frames = 0;
    logic [7:0] log_b [14];
    logic [6:0][7:0] acc_data = '0;
    logic [7:0] acc_len = 8'h00;
    logic [3:0] acc_tag = 4'h0;
    bit chk_rdy = 1'b0;

    bit cfg_rand = 1'b0, cfg_lit = 1'b0, cfg_no0 = 1'b0, cfg_allow_to = 1'b0;
    int cfg_n0 = 1, cfg_n1 = 1;
    int cfg_p0 [2] = '{0, 0};
    int cfg_p1 [2] = '{0, 0};
    int ready_mode = 0;
    int rcyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0][7:0] rnd_pay();
        logic [6:0][7:0] r;
        for (int i = 0; i < 7; i++) r[i] = 8'($urandom);
        return r;
    endfunction

    // Expected frame straight from the frame layout table.
    task automatic push_frame(input logic [6:0][7:0] d, input logic [7:0] l, input logic [3:0] t,
                              input logic [7:0] c0, input logic [7:0] r0, input logic [7:0] k0,
                              input logic [3:0] c1, input logic [3:0] r1, input logic [3:0] k1);
        exp_q.push_back(SYNC);
        exp_q.push_back(l);
        exp_q.push_back({t, c1});
        exp_q.push_back({r1, k1});
        for (int i = 0; i < 7; i++) exp_q.push_back(d[i]);
        exp_q.push_back(c0);
        exp_q.push_back(r0);
        exp_q.push_back(k0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_frm_ready"}, frm_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_starts"}, {crc0_start, crc1_start}, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_eng_data"}, eng_data, 0);
        chk({tag, "_eng_hdr"}, {eng_msg_len, eng_msg_tag}, 0);
    endtask

    // Compare process: every cycle, outputs against the expected-frame queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            byte_cnt = 0;
            acc_data = '0;
            acc_len  = 8'h00;
            acc_tag  = 4'h0;
            chk_rdy  = 1'b0;
        end else begin
            chk("eng_data_stable", eng_data, acc_data);
            chk("eng_hdr_stable", {eng_msg_len, eng_msg_tag}, {acc_len, acc_tag});
            chk("start_pair", crc0_start, crc1_start);
            if (chk_rdy) begin
                chk("ready_after_last", frm_ready, 1);
                chk_rdy = 1'b0;
            end
            if (crc0_start) n_st0++;
            if (crc1_start) n_st1++;
            if (timeout_err) n_to++;
            if (byte_cnt > 0) chk("valid_hold", tx_valid, 1);
            if (tx_valid) begin
                chk("busy_send", busy, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", tx_data, 'x);
                end else begin
                    chk("tx_data", tx_data, exp_q[0]);
                    if (tx_ready) begin
                        log_b[byte_cnt] = tx_data;
                        void'(exp_q.pop_front());
                        byte_cnt++;
                        if (byte_cnt == 14) begin
                            byte_cnt = 0;
                            frames_done++;
                            chk_rdy = 1'b1;
                        end
                    end
                end
            end
            if (frm_valid && frm_ready) begin
                acc_data = data_in;
                acc_len  = msg_len;
                acc_tag  = msg_tag;
                n_acc++;
            end
        end
    end

    // Stub FEC engine: done pulses at chosen WAIT-cycle offsets k (k=0 is the first WAIT cycle).
    initial begin : engine
        int p0 [2];
        int p1 [2];
        int n0, n1, c, last, s0, s1;
        bit no0;
        logic [7:0] c0 [2];
        logic [7:0] r0 [2];
        logic [7:0] k0 [2];
        logic [3:0] c1 [2];
        logic [3:0] r1 [2];
        logic [3:0] k1 [2];
        enc0_done = 0; enc1_done = 0;
        crc0_data = 0; enc0_row_p = 0; enc0_col_p = 0;
        crc1_data = 0; enc1_row_p = 0; enc1_col_p = 0;
        forever begin
            @(negedge clk);
            if (rst_n && crc0_start) begin
                if (cfg_rand) begin
                    no0   = cfg_allow_to && ($urandom_range(0, 5) == 0);
                    n0    = $urandom_range(1, 2);
                    n1    = $urandom_range(1, 2);
                    p0[0] = $urandom_range(0, 6);
                    p0[1] = p0[0] + $urandom_range(1, 4);
                    p1[0] = $urandom_range(0, 6);
                    p1[1] = p1[0] + $urandom_range(1, 4);
                end else begin
                    no0 = cfg_no0; n0 = cfg_n0; n1 = cfg_n1;
                    p0 = cfg_p0; p1 = cfg_p1;
                end
                for (int i = 0; i < 2; i++) begin
                    c0[i] = 8'($urandom); r0[i] = 8'($urandom); k0[i] = 8'($urandom);
                    c1[i] = 4'($urandom); r1[i] = 4'($urandom); k1[i] = 4'($urandom);
                end
                if (cfg_lit) begin
                    c0[0] = 8'h5C; r0[0] = 8'h12; k0[0] = 8'h34;
                    c1[0] = 4'h9;  r1[0] = 4'hA;  k1[0] = 4'h6;
                end
                c = -1;
                if (no0) begin
                    exp_to++;
                    last = TO;
                end else begin
                    c    = (p0[0] > p1[0]) ? p0[0] : p1[0];
                    last = c + 1;
                    if (n0 == 2 && p0[1] > last) last = p0[1];
                    if (n1 == 2 && p1[1] > last) last = p1[1];
                    s0 = (n0 == 2 && p0[1] <= c) ? 1 : 0;
                    s1 = (n1 == 2 && p1[1] <= c) ? 1 : 0;
                    push_frame(acc_data, acc_len, acc_tag, c0[s0], r0[s0], k0[s0], c1[s1], r1[s1], k1[s1]);
                    exp_frames++;
                end
                for (int k = 0; k <= last; k++) begin
                    @(posedge clk); #1;
                    enc0_done = 0; crc0_data = 8'($urandom); enc0_row_p = 8'($urandom); enc0_col_p = 8'($urandom);
                    enc1_done = 0; crc1_data = 4'($urandom); enc1_row_p = 4'($urandom); enc1_col_p = 4'($urandom);
                    for (int i = 0; i < n0; i++)
                        if (!no0 && k == p0[i]) begin
                            enc0_done = 1; crc0_data = c0[i]; enc0_row_p = r0[i]; enc0_col_p = k0[i];
                        end
                    for (int i = 0; i < n1; i++)
                        if (k == p1[i]) begin
                            enc1_done = 1; crc1_data = c1[i]; enc1_row_p = r1[i]; enc1_col_p = k1[i];
                        end
                    if (!no0 && k == c + 1) enc0_done = 1;  // stray done in SEND must be ignored
                    @(negedge clk);
                    if (no0) begin
                        chk("timeout_pulse", timeout_err, (k == TO - 1));
                        chk("no_valid_on_timeout", tx_valid, 0);
                        if (k < TO) chk("busy_wait", busy, 1);
                        else        chk("ready_after_timeout", frm_ready, 1);
                    end else begin
                        chk("tx_valid_latency", tx_valid, (k > c));
                        chk("no_timeout", timeout_err, 0);
                    end
                end
                @(posedge clk); #1;
                enc0_done = 0; enc1_done = 0;
            end
        end
    end

    initial begin : ready_drv
        tx_ready = 0;
        forever begin
            @(posedge clk); #1;
            rcyc++;
            case (ready_mode)
                0:       tx_ready = 1;
                1:       tx_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_frame(input logic [6:0][7:0] d, input logic [7:0] l, input logic [3:0] t);
        int base, n;
        base = frames_done + n_to;
        @(posedge clk); #1;
        frm_valid = 1; data_in = d; msg_len = l; msg_tag = t;
        n = 0;
        while (!frm_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        frm_valid = 0; data_in = rnd_pay(); msg_len = 8'($urandom); msg_tag = 4'($urandom);
        n = 0;
        while (frames_done + n_to == base && n < 3000) begin @(negedge clk); n++; end
        chk("frame_ends", (n < 3000), 1);
        @(negedge clk);
        chk("idle_after_frame", {frm_ready, busy}, 2'b10);
    endtask

    task automatic set_fixed(input bit no0, input int n0, input int a0, input int b0,
                             input int n1, input int a1, input int b1);
        cfg_rand = 0; cfg_no0 = no0;
        cfg_n0 = n0; cfg_p0[0] = a0; cfg_p0[1] = b0;
        cfg_n1 = n1; cfg_p1[0] = a1; cfg_p1[1] = b1;
    endtask

    initial begin : main
        logic [6:0][7:0] d;
        logic [7:0] lit [14];
        int n, base_acc, base_end;

        frm_valid = 0; data_in = '0; msg_len = 0; msg_tag = 0;
        rst_n = 0;
        #12;
        check_all_zero("reset");
        #10 rst_n = 1;
        #1 chk("ready_low_before_edge", frm_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_reset", frm_ready, 1);
        chk("busy_after_reset", busy, 0);

        // Known frame with fixed engine results pins the layout.
        cfg_lit = 1;
        set_fixed(0, 1, 2, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) d[i] = 8'(i + 1);
        send_frame(d, 8'h07, 4'h3);
        cfg_lit = 0;
        lit = '{8'hA5, 8'h07, 8'h39, 8'hA6, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h5C, 8'h12, 8'h34};
        for (int i = 0; i < 14; i++) chk($sformatf("lit_byte%0d", i), log_b[i], lit[i]);

        // enc1 three cycles ahead of enc0, then both together.
        set_fixed(0, 1, 3, 0, 1, 0, 0);
        send_frame(rnd_pay(), 8'($urandom), 4'($urandom));
        set_fixed(0, 1, 2, 0, 1, 2, 0);
        send_frame(rnd_pay(), 8'($urandom), 4'($urandom));

        // Stall pattern 1,0,0,1.
        ready_mode = 1; cfg_rand = 1; cfg_allow_to = 0;
        repeat (3) send_frame(rnd_pay(), 8'($urandom), 4'($urandom));
        ready_mode = 0;

        // Timeout, then a normal frame, then completion on the expiry cycle.
        set_fixed(1, 1, 0, 0, 1, 3, 0);
        send_frame(rnd_pay(), 8'($urandom), 4'($urandom));
        chk("one_timeout", n_to, 1);
        set_fixed(0, 1, 1, 0, 1, 4, 0);
        send_frame(rnd_pay(), 8'($urandom), 4'($urandom));
        set_fixed(0, 1, TO - 1, 0, 1, TO - 1, 0);
        send_frame(rnd_pay(), 8'($urandom), 4'($urandom));

        // Repeated dones: overwrite before completion, ignored after.
        set_fixed(0, 1, 5, 0, 2, 1, 3);
        send_frame(rnd_pay(), 8'($urandom), 4'($urandom));
        set_fixed(0, 2, 0, 6, 1, 4, 0);
        send_frame(rnd_pay(), 8'($urandom), 4'($urandom));

        // Reset while byte 5 is on the wire.
        ready_mode = 1;
        set_fixed(0, 1, 1, 0, 1, 2, 0);
        @(posedge clk); #1;
        frm_valid = 1; data_in = rnd_pay(); msg_len = 8'($urandom); msg_tag = 4'($urandom);
        n = 0;
        while (!frm_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        frm_valid = 0;
        n = 0;
        while (!(byte_cnt == 5 && tx_valid) && n < 500) begin @(negedge clk); n++; end
        chk("reach_byte5", (n < 500), 1);
        #2 rst_n = 0;
        #1 check_all_zero("midreset");
        exp_frames--;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1;
        #1 chk("ready_low_after_release", frm_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_release", frm_ready, 1);
        repeat (20) @(negedge clk);
        chk("no_residual_bytes", tx_valid, 0);

        // frm_valid held high with fresh data every cycle.
        ready_mode = 2; cfg_rand = 1; cfg_allow_to = 1;
        base_acc = n_acc;
        base_end = frames_done + n_to;
        @(posedge clk); #1;
        frm_valid = 1;
        n = 0;
        while (n_acc < base_acc + 6 && n < 20000) begin
            data_in = rnd_pay(); msg_len = 8'($urandom); msg_tag = 4'($urandom);
            @(posedge clk); #1;
            n++;
        end
        frm_valid = 0;
        chk("b2b_accepts", (n < 20000), 1);
        n = 0;
        while (frames_done + n_to < base_end + 6 && n < 5000) begin @(negedge clk); n++; end
        chk("b2b_done", (n < 5000), 1);

        repeat (15) begin
            ready_mode = $urandom_range(0, 2);
            send_frame(rnd_pay(), 8'($urandom), 4'($urandom));
        end

        chk("start0_per_frame", n_st0, n_acc);
        chk("start1_per_frame", n_st1, n_acc);
        chk("timeout_count", n_to, exp_to);
        chk("frame_count", frames_done, exp_frames);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
